if_id_queue: RTL and testbench

Instruction fetch queue and IF/ID pipeline register. It sits between the PC counter plus instruction ROM (IF stage) and the decode stage. It captures each fetched {pc, inst} pair, buffers up to DEPTH entries so that decode stalls do not lose fetched instructions, and presents one registered instruction per cycle to ID. It raises a stall request to the ctrl module when full, and discards all contents on a pipeline flush.

---
 rtl/if_id_queue_pkg.sv | 22 ++
 rtl/if_fifo.sv | 64 ++++++
 rtl/if_id_queue.sv | 93 +++++++++
 tb/tb_if_id_queue.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/if_id_queue_pkg.sv
// Shared constants for the IF/ID fetch queue: reset level, zero/nop words,
// bus widths, and the {pc, inst} entry packing helper.
package if_id_queue_pkg;

  localparam logic RstEnable = 1'b1;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;
  localparam int EntryW      = InstAddrBus + InstBus;

  localparam logic [InstAddrBus-1:0] ZeroWord = '0;
  localparam logic [InstBus-1:0]     NopInst  = '0;

  // Queue entries are stored as {pc, inst}, pc in the upper half.
  function automatic logic [EntryW-1:0] pack_entry(
    input logic [InstAddrBus-1:0] pc,
    input logic [InstBus-1:0]     inst
  );
    return {pc, inst};
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Circular buffer holding fetched {pc, inst} entries between IF and ID.
// Provides storage, read/write pointers, an occupancy count (0..DEPTH)
// and full/empty flags. The head entry is readable combinationally.
// A write while full is accepted only if a read happens in the same cycle;
// otherwise it is dropped.
module if_fifo
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [EntryW-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [EntryW-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [EntryW-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_rd;
  logic              do_wr;

  assign full    = (count == FullCount);
  assign empty   = (count == '0);
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset and flush both empty the queue.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst == RstEnable || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage write port.
  // NOTE: the storage array is deliberately not reset; validity is tracked
  // by count/pointers, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/if_id_queue.sv
// Instruction fetch queue plus IF/ID pipeline register.
// Captures fetched {pc, inst} pairs, buffers them in if_fifo so decode
// stalls lose nothing, and presents one registered instruction per cycle.
// Optional feature macro: IFQ_BYPASS_EN -- when defined, a push into an
// empty queue while ID advances goes straight to the output register
// (1-cycle latency); when undefined every push goes through storage
// (2-cycle minimum latency).
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             ctrl_signal,
  input  logic                   flush,
  input  logic                   if_valid,
  input  logic [InstAddrBus-1:0] if_pc,
  input  logic [InstBus-1:0]     if_inst,
  output logic [InstAddrBus-1:0] id_pc,
  output logic [InstBus-1:0]     id_inst,
  output logic                   id_valid,
  output logic                   stallreq
);

  localparam int AW = $clog2(DEPTH);

  logic              push;
  logic              advance;
  logic              bypass;
  logic              pop;
  logic              wr_en;
  logic              fifo_empty;
  logic              fifo_full;
  logic [AW:0]       fifo_count;
  logic [EntryW-1:0] head;
  logic              unused_ctrl;

  // Only the IF and ID stall bits matter to this stage.
  assign unused_ctrl = ^{ctrl_signal[5:3], ctrl_signal[0], fifo_count};

  assign push    = if_valid & ~ctrl_signal[1] & ~flush;
  assign advance = ~ctrl_signal[2] & ~flush;
  assign pop     = advance & ~fifo_empty;

`ifdef IFQ_BYPASS_EN
  assign bypass = advance & fifo_empty & push;
`else
  assign bypass = 1'b0;
`endif

  assign wr_en    = push & ~bypass;
  assign stallreq = fifo_full;

  if_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear   (flush),
    .wr_en   (wr_en),
    .wr_data (pack_entry(if_pc, if_inst)),
    .rd_en   (pop),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // IF/ID output register: head of queue, bypassed fetch, or bubble; holds on ID stall.
  always_ff @(posedge clk) begin
    if (rst == RstEnable || flush) begin
      id_valid <= 1'b0;
      id_pc    <= ZeroWord;
      id_inst  <= NopInst;
    end else if (advance) begin
      if (!fifo_empty) begin
        id_valid <= 1'b1;
        id_pc    <= head[EntryW-1:InstBus];
        id_inst  <= head[InstBus-1:0];
      end else if (bypass) begin
        id_valid <= 1'b1;
        id_pc    <= if_pc;
        id_inst  <= if_inst;
      end else begin
        id_valid <= 1'b0;
        id_pc    <= ZeroWord;
        id_inst  <= NopInst;
      end
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios followed by
// randomized traffic, compared every cycle against a queue-based model.
module tb_if_id_queue;

  localparam int DEPTH = 4;

`ifdef IFQ_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  ctrl_signal = '0;
  logic        flush = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_pc = '0;
  logic [31:0] if_inst = '0;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        stallreq;

  always #5 clk = ~clk;

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .ctrl_signal (ctrl_signal),
    .flush       (flush),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .id_pc       (id_pc),
    .id_inst     (id_inst),
    .id_valid    (id_valid),
    .stallreq    (stallreq)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a plain queue of pending {pc, inst} plus the ID view.
  logic [63:0] model_q [$];
  logic        m_valid = 1'b0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_inst = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic [5:0] cs, input logic fl,
                              input logic v, input logic [31:0] pc, input logic [31:0] inst);
    bit          do_push;
    bit          do_adv;
    bit          straight;
    logic [63:0] e;
    do_push = v && !cs[1] && !fl;
    do_adv  = !cs[2] && !fl;
    if (r || fl) begin
      model_q.delete();
      m_valid = 1'b0;
      m_pc    = '0;
      m_inst  = '0;
    end else begin
      straight = Byp && do_adv && do_push && (model_q.size() == 0);
      if (do_adv) begin
        if (model_q.size() > 0) begin
          e       = model_q.pop_front();
          m_valid = 1'b1;
          m_pc    = e[63:32];
          m_inst  = e[31:0];
        end else if (straight) begin
          m_valid = 1'b1;
          m_pc    = pc;
          m_inst  = inst;
        end else begin
          m_valid = 1'b0;
          m_pc    = '0;
          m_inst  = '0;
        end
      end
      if (do_push && !straight && model_q.size() < DEPTH)
        model_q.push_back({pc, inst});
    end
  endtask

  // One clock: drive on the falling edge, update model at the rising edge,
  // compare shortly after it.
  task automatic step(input logic r, input logic [5:0] cs, input logic fl,
                      input logic v, input logic [31:0] pc);
    logic [31:0] inst;
    inst = $urandom;
    @(negedge clk);
    rst         = r;
    ctrl_signal = cs;
    flush       = fl;
    if_valid    = v;
    if_pc       = pc;
    if_inst     = inst;
    @(posedge clk);
    model_update(r, cs, fl, v, pc, inst);
    #1;
    check("id_valid", 64'(id_valid), 64'(m_valid));
    check("id_pc",    64'(id_pc),    64'(m_pc));
    check("id_inst",  64'(id_inst),  64'(m_inst));
    check("stallreq", 64'(stallreq), 64'(model_q.size() == DEPTH));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 6'b000000, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] pc_next;
    logic [5:0]  cs;
    logic        fl;
    logic        r;

    // Reset
    step(1'b1, 6'b000000, 1'b0, 1'b1, 32'hDEAD_0000);
    step(1'b1, 6'b000000, 1'b0, 1'b0, 32'h0);
    check("reset_bubble", 64'({id_valid, id_pc, id_inst}), 64'h0);

    // Stream 0x0, 0x4, 0x8 with no stalls
    for (int i = 0; i < 3; i++) step(1'b0, 6'b000000, 1'b0, 1'b1, 32'(i * 4));
    idle(3);

    // ID stalled for 6 cycles while pushing 0x10..0x1C; queue fills
    for (int i = 0; i < 6; i++)
      step(1'b0, 6'b000100, 1'b0, (i < 4), 32'h10 + 32'(i * 4));
    check("full_stallreq", 64'(stallreq), 64'h1);

    // Honour stallreq: IF stalled, ID advances, queue drains in order
    for (int i = 0; i < 6; i++) step(1'b0, 6'b000011, 1'b0, 1'b1, 32'h200 + 32'(i * 4));
    idle(1);

    // Fill to DEPTH, then simultaneous pop and push of 0x50
    for (int i = 0; i < 4; i++) step(1'b0, 6'b000100, 1'b0, 1'b1, 32'h30 + 32'(i * 4));
    step(1'b0, 6'b000000, 1'b0, 1'b1, 32'h50);
    check("pop_push_full", 64'(stallreq), 64'h1);
    idle(6);

    // Three queued entries then flush; next push 0x40 appears
    for (int i = 0; i < 3; i++) step(1'b0, 6'b000100, 1'b0, 1'b1, 32'h60 + 32'(i * 4));
    step(1'b0, 6'b000000, 1'b1, 1'b1, 32'h70);
    check("flush_bubble", 64'({id_valid, id_inst, stallreq}), 64'h0);
    step(1'b0, 6'b000000, 1'b0, 1'b1, 32'h40);
    idle(3);

    // Reset mid-stream with two entries queued
    for (int i = 0; i < 2; i++) step(1'b0, 6'b000100, 1'b0, 1'b1, 32'h80 + 32'(i * 4));
    step(1'b1, 6'b000000, 1'b0, 1'b1, 32'h90);
    check("rst_outputs", 64'({id_valid, id_pc, id_inst, stallreq}), 64'h0);
    idle(3);

    // Randomized traffic
    pc_next = 32'h1000;
    for (int i = 0; i < 3000; i++) begin
      cs = 6'($urandom);
      cs[2] = ($urandom_range(0, 9) < 3);
      cs[1] = ($urandom_range(0, 9) < 2);
      if (model_q.size() == DEPTH && $urandom_range(0, 3) != 0) cs[1:0] = 2'b11;
      fl = ($urandom_range(0, 59) == 0);
      r  = ($urandom_range(0, 199) == 0);
      step(r, cs, fl, $urandom_range(0, 9) < 8, pc_next);
      pc_next = pc_next + 32'h4;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
